// File: rtl/plot_fb_if.sv
// Pixel-plot bus from the shape renderers into the framebuffer sink.
interface plot_fb_if;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   modport master (output vga_x, output vga_y, output vga_colour, output vga_plot);
   modport slave  (input  vga_x, input  vga_y, input  vga_colour, input  vga_plot);
endinterface

// File: rtl/plot_fb_sink.sv
// Framebuffer sink: clips and writes renderer plots, runs a whole-screen clear, registered read port.
// Optional plot/reject statistics counters are built when PLOT_STATS_EN is defined.
module plot_fb_sink #(
   parameter int unsigned WIDTH  = 160,
   parameter int unsigned HEIGHT = 120
) (
   input  logic        clk,
   input  logic        rst,
   plot_fb_if.slave    vga,
   input  logic        clear_start,
   input  logic [2:0]  clear_colour,
   output logic        clear_busy,
   output logic        clear_done,
   input  logic [7:0]  rd_x,
   input  logic [6:0]  rd_y,
   output logic [2:0]  rd_colour,
   output logic [15:0] plot_count,
   output logic [15:0] reject_count
);

   localparam int unsigned XW    = 8;
   localparam int unsigned YW    = 7;
   localparam int unsigned CW    = 3;
   localparam int unsigned AW    = 15;
   localparam int unsigned NW    = 16;
   localparam int unsigned DEPTH = WIDTH * HEIGHT;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   state_t        state;
   logic [XW-1:0] clr_x;
   logic [YW-1:0] clr_y;
   logic [CW-1:0] clr_colour;

   logic [CW-1:0] fb [DEPTH];

   logic          on_screen_c;
   logic          plot_ok_c;
   logic          rd_in_c;
   logic          wr_en_c;
   logic [AW-1:0] wr_addr_c;
   logic [CW-1:0] wr_data_c;
   logic [AW-1:0] rd_addr_c;

   function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return AW'(y) * AW'(WIDTH) + AW'(x);
   endfunction

   assign on_screen_c = (32'(vga.vga_x) < WIDTH) && (32'(vga.vga_y) < HEIGHT);
   assign plot_ok_c   = vga.vga_plot && on_screen_c && (state != S_CLEAR);
   assign rd_in_c     = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
   assign rd_addr_c   = pix_addr(rd_x, rd_y);

   // Clear engine owns the write port while clearing; plots use it otherwise.
   always_comb begin
      wr_en_c   = 1'b0;
      wr_addr_c = '0;
      wr_data_c = '0;
      if (!rst) begin
         if (state == S_CLEAR) begin
            wr_en_c   = 1'b1;
            wr_addr_c = pix_addr(clr_x, clr_y);
            wr_data_c = clr_colour;
         end else if (plot_ok_c) begin
            wr_en_c   = 1'b1;
            wr_addr_c = pix_addr(vga.vga_x, vga.vga_y);
            wr_data_c = vga.vga_colour;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_c) fb[wr_addr_c] <= wr_data_c;
   end

   // Read-first: the array read sees the value before this edge's write.
   always_ff @(posedge clk) begin
      if (rst)          rd_colour <= '0;
      else if (rd_in_c) rd_colour <= fb[rd_addr_c];
      else              rd_colour <= '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
         clr_x      <= '0;
         clr_y      <= '0;
         clr_colour <= '0;
      end else begin
         clear_done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (clear_start) begin
                  state      <= S_CLEAR;
                  clear_busy <= 1'b1;
                  clr_colour <= clear_colour;
                  clr_x      <= '0;
                  clr_y      <= '0;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CLEAR: begin
               if (clr_x == XW'(WIDTH - 1)) begin
                  clr_x <= '0;
                  if (clr_y == YW'(HEIGHT - 1)) begin
                     state      <= S_DONE;
                     clear_busy <= 1'b0;
                     clear_done <= 1'b1;
                     clr_y      <= '0;
                  end else begin
                     clr_y <= clr_y + YW'(1);
                  end
               end else begin
                  clr_x <= clr_x + XW'(1);
               end
            end
            default: begin
               state      <= S_IDLE;
               clear_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef PLOT_STATS_EN
   logic reject_c;

   // Anything strobed but not written is a reject, including on-screen plots during a clear.
   assign reject_c = vga.vga_plot && !plot_ok_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         plot_count   <= '0;
         reject_count <= '0;
      end else begin
         if (plot_ok_c && (plot_count != {NW{1'b1}}))
            plot_count <= plot_count + NW'(1);
         if (reject_c && (reject_count != {NW{1'b1}}))
            reject_count <= reject_count + NW'(1);
      end
   end
`else
   assign plot_count   = '0;
   assign reject_count = '0;
`endif

endmodule
